// File: rtl/gray_rx_tracker.sv
// Gray-coded position tracker: decodes 4-bit Gray samples, checks unit steps and tracks lock.
// Define GRAY_RX_SYNC_EN to insert two register stages on g/g_valid ahead of the decoder.
module gray_rx_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] g,
    input  logic       g_valid,
    input  logic       clr_err,
    output logic [3:0] b,
    output logic       b_valid,
    output logic       dir,
    output logic       step_err,
    output logic [3:0] err_cnt,
    output logic       locked
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t     state_q, state_d;
    logic       run_q, run_d;
    logic [3:0] g_s;
    logic       vld_s;
    logic       has_prev;
    logic [3:0] bin_s;
    logic [3:0] delta_s;
    logic       legal_s;
    logic       illegal_s;

    function automatic logic [3:0] gray2bin(input logic [3:0] gv);
        logic [3:0] r;
        r[3] = gv[3];
        for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
        return r;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

`ifdef GRAY_RX_SYNC_EN
    logic [3:0] g_p0, g_p1;
    logic       vld_p0, vld_p1;

    // Sync stages: cleared on reset so nothing in flight survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_p0   <= 4'd0;
            g_p1   <= 4'd0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            g_p0   <= g;
            g_p1   <= g_p0;
            vld_p0 <= g_valid;
            vld_p1 <= vld_p0;
        end
    end

    assign g_s   = g_p1;
    assign vld_s = vld_p1;
`else
    assign g_s   = g;
    assign vld_s = g_valid;
`endif

    // Decode / step check; b doubles as the previous accepted sample.
    assign bin_s     = gray2bin(g_s);
    assign delta_s   = bin_s - b;
    assign legal_s   = (delta_s == 4'd0) || (delta_s == 4'd1) || (delta_s == 4'd15);
    assign illegal_s = vld_s && has_prev && !legal_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            b        <= 4'd0;
            b_valid  <= 1'b0;
            dir      <= 1'b1;
            step_err <= 1'b0;
            err_cnt  <= 4'd0;
            has_prev <= 1'b0;
        end else begin
            b_valid  <= vld_s;
            step_err <= illegal_s;
            if (vld_s) begin
                b        <= bin_s;
                has_prev <= 1'b1;
                if (has_prev && delta_s == 4'd1)  dir <= 1'b1;
                if (has_prev && delta_s == 4'd15) dir <= 1'b0;
            end
            if (clr_err)        err_cnt <= illegal_s ? 4'd1 : 4'd0;
            else if (illegal_s) err_cnt <= sat_inc(err_cnt);
        end
    end

    // Lock FSM follows the registered sample outcome one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            IDLE: begin
                if (b_valid) state_d = TRACK;
            end
            TRACK: begin
                if (b_valid && step_err) begin
                    state_d = FAULT;
                    run_d   = 1'b0;
                end
            end
            FAULT: begin
                if (b_valid) begin
                    if (step_err) begin
                        run_d = 1'b0;
                    end else if (run_q) begin
                        state_d = TRACK;
                        run_d   = 1'b0;
                    end else begin
                        run_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 1'b0;
            end
        endcase
    end

    assign locked = (state_q == TRACK);

endmodule
